// File: rtl/spi_cfg_master_if.sv
// Request/response port between a sequencer FSM and spi_cfg_master.
// The sequencer side uses the master modport; the SPI engine uses slave.
interface spi_cfg_master_if #(
  parameter int WORD_W   = 16,
  parameter int CS_SEL_W = 1
);
  logic                req_valid;
  logic                req_ready;
  logic [WORD_W-1:0]   req_word;
  logic [CS_SEL_W-1:0] req_cs;
  logic                req_read;
  logic                rsp_valid;
  logic [WORD_W-1:0]   rsp_data;

  modport master (
    output req_valid, req_word, req_cs, req_read,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_word, req_cs, req_read,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/spi_cfg_master.sv
// Parametrised SPI configuration master: MSB-first writes with optional SDI
// readback, programmable SCLK divider and multiple active-low chip selects.
//
// state      | meaning
// S_IDLE     | lines idle, req_ready high, waiting for a request
// S_SHIFT_HI | SCLK high for DIV cycles, SDATA launched on the first cycle
// S_SHIFT_LO | SCLK low for DIV cycles, slave samples on the falling edge
// S_END      | deselect, pulse rsp_valid for reads
// S_GAP      | DIV idle cycles before the next request is accepted
module spi_cfg_master #(
  parameter int WORD_W   = 16,
  parameter int DIV      = 2,
  parameter int NUM_CS   = 2,
  parameter int CS_SEL_W = 1
) (
  input  logic              clock,
  input  logic              reset,
  spi_cfg_master_if.slave   host,
  output logic              busy,
  output logic              SCLK,
  output logic              SDATA,
  input  logic              SDI,
  output logic [NUM_CS-1:0] SEN
);
  localparam int TMR_W = $clog2(DIV);
  localparam int CNT_W = $clog2(WORD_W);
  localparam logic [TMR_W-1:0]    TMR_LOAD = TMR_W'(DIV - 1);
  localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [CS_SEL_W:0]   CS_LIMIT = (CS_SEL_W + 1)'(NUM_CS);

  typedef enum logic [2:0] {S_IDLE, S_SHIFT_HI, S_SHIFT_LO, S_END, S_GAP} state_t;

  state_t            state;
  logic [TMR_W-1:0]  tmr;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] word_sr;
  logic [WORD_W-1:0] cap;
  logic              read_q;
  logic              ready_q;
  logic              rsp_valid_q;
  logic [WORD_W-1:0] rsp_data_q;
  logic              cs_ok;

  assign cs_ok          = {1'b0, host.req_cs} < CS_LIMIT;
  assign host.req_ready = ready_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;
  assign busy           = ~ready_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= S_IDLE;
      tmr         <= '0;
      bit_cnt     <= '0;
      word_sr     <= '0;
      cap         <= '0;
      read_q      <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      SCLK        <= 1'b1;
      SDATA       <= 1'b0;
      SEN         <= '1;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (host.req_valid && ready_q) begin
            ready_q <= 1'b0;
            word_sr <= host.req_word;
            read_q  <= host.req_read;
            cap     <= '0;
            bit_cnt <= '0;
            tmr     <= TMR_LOAD;
            // An out-of-range select runs a dummy transaction with no bus activity.
            if (cs_ok) begin
              for (int i = 0; i < NUM_CS; i++)
                SEN[i] <= !(host.req_cs == CS_SEL_W'(i));
              state <= S_SHIFT_HI;
            end else begin
              state <= S_END;
            end
          end
        end
        S_SHIFT_HI: begin
          if (tmr == TMR_LOAD)
            SDATA <= word_sr[WORD_W-1];
          if (tmr == '0) begin
            SCLK  <= 1'b0;
            tmr   <= TMR_LOAD;
            state <= S_SHIFT_LO;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        S_SHIFT_LO: begin
          if (tmr == '0) begin
            SCLK    <= 1'b1;
            cap     <= {cap[WORD_W-2:0], SDI};
            word_sr <= {word_sr[WORD_W-2:0], 1'b0};
            tmr     <= TMR_LOAD;
            if (bit_cnt == LAST_BIT) begin
              state <= S_END;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              state   <= S_SHIFT_HI;
            end
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        S_END: begin
          SEN   <= '1;
          SDATA <= 1'b0;
          if (read_q) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= cap;
          end
          tmr   <= TMR_LOAD;
          state <= S_GAP;
        end
        S_GAP: begin
          if (tmr == '0) begin
            bit_cnt <= '0;
            ready_q <= 1'b1;
            state   <= S_IDLE;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master: a 16-bit/DIV=2 instance with a 2-bit
// select (for the invalid-select case) and a 24-bit/DIV=4 instance.
module tb_spi_cfg_master;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  spi_cfg_master_if #(.WORD_W(16), .CS_SEL_W(2)) if_a ();
  spi_cfg_master_if #(.WORD_W(24), .CS_SEL_W(1)) if_b ();

  logic       a_busy, a_sclk, a_sdata;
  logic       b_busy, b_sclk, b_sdata;
  logic       a_sdi = 1'b0;
  logic       b_sdi = 1'b0;
  logic [1:0] a_sen, b_sen;

  spi_cfg_master #(.WORD_W(16), .DIV(2), .NUM_CS(2), .CS_SEL_W(2)) dut_a (
    .clock(clock), .reset(reset), .host(if_a.slave), .busy(a_busy),
    .SCLK(a_sclk), .SDATA(a_sdata), .SDI(a_sdi), .SEN(a_sen));

  spi_cfg_master #(.WORD_W(24), .DIV(4), .NUM_CS(2), .CS_SEL_W(1)) dut_b (
    .clock(clock), .reset(reset), .host(if_b.slave), .busy(b_busy),
    .SCLK(b_sclk), .SDATA(b_sdata), .SDI(b_sdi), .SEN(b_sen));

  // Slave models: restart on select, capture SDATA and launch SDI on SCLK fall.
  logic        a_sen_all, b_sen_all;
  logic [15:0] a_rx = '0, a_slave_word = '0;
  logic [23:0] b_rx = '0, b_slave_word = '0;
  int          a_bit = 0, b_bit = 0;
  assign a_sen_all = &a_sen;
  assign b_sen_all = &b_sen;

  always @(negedge a_sclk or negedge a_sen_all) begin
    if (a_sclk) begin
      a_rx = '0; a_bit = 0;
    end else if (!a_sen_all && a_bit < 16) begin
      a_rx  = {a_rx[14:0], a_sdata};
      a_sdi = a_slave_word[15 - a_bit];
      a_bit++;
    end
  end

  always @(negedge b_sclk or negedge b_sen_all) begin
    if (b_sclk) begin
      b_rx = '0; b_bit = 0;
    end else if (!b_sen_all && b_bit < 24) begin
      b_rx  = {b_rx[22:0], b_sdata};
      b_sdi = b_slave_word[23 - b_bit];
      b_bit++;
    end
  end

  bit          sel = 1'b0;
  logic        m_sclk, m_ready, m_rsp_valid;
  logic [1:0]  m_sen;
  logic [31:0] m_rsp_data;
  always_comb begin
    if (sel) begin
      m_sclk = b_sclk; m_sen = b_sen; m_ready = if_b.req_ready;
      m_rsp_valid = if_b.rsp_valid; m_rsp_data = {8'h00, if_b.rsp_data};
    end else begin
      m_sclk = a_sclk; m_sen = a_sen; m_ready = if_a.req_ready;
      m_rsp_valid = if_a.rsp_valid; m_rsp_data = {16'h0000, if_a.rsp_data};
    end
  end

  int checks = 0, errors = 0;
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int m_sen_low0, m_sen_low1, m_rsp_cnt, m_rsp_t, m_ready_t, m_falls, m_rises;
  int m_width_bad, m_first_fall, m_bad_idle, m_last_low;
  logic [31:0] m_data;

  // Samples on falling clock; t=0 is the first sample after the accepting edge.
  task automatic monitor(int div, int budget);
    logic prev = 1'b1;
    int   last = 0;
    m_sen_low0 = 0; m_sen_low1 = 0; m_rsp_cnt = 0; m_rsp_t = -1; m_ready_t = -1;
    m_falls = 0; m_rises = 0; m_width_bad = 0; m_first_fall = -1; m_bad_idle = 0;
    m_last_low = -1; m_data = '0;
    for (int t = 0; t < budget; t++) begin
      if (m_ready) begin m_ready_t = t; break; end
      if (!m_sen[0]) m_sen_low0++;
      if (!m_sen[1]) m_sen_low1++;
      if (m_sen != 2'b11) m_last_low = t;
      if (m_sen == 2'b00) m_bad_idle++;
      if (m_sen == 2'b11 && !m_sclk) m_bad_idle++;
      if (m_rsp_valid) begin
        m_rsp_cnt++;
        if (m_rsp_t < 0) m_rsp_t = t;
        m_data = m_rsp_data;
      end
      if (m_sclk !== prev) begin
        if (t - last != div) m_width_bad++;
        last = t;
        if (!m_sclk) begin
          m_falls++;
          if (m_first_fall < 0) m_first_fall = t;
        end else m_rises++;
      end
      prev = m_sclk;
      @(negedge clock);
    end
  endtask

  task automatic wait_accept();
    int n = 0;
    while (!m_ready && n < 300) begin @(negedge clock); n++; end
    if (n >= 300) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic issue_a(logic [15:0] word, logic [1:0] cs, bit rd);
    sel = 1'b0;
    if_a.req_word = word; if_a.req_cs = cs; if_a.req_read = rd; if_a.req_valid = 1'b1;
    wait_accept();
  endtask

  initial begin
    int pulses;
    if_a.req_valid = 1'b0; if_a.req_word = '0; if_a.req_cs = '0; if_a.req_read = 1'b0;
    if_b.req_valid = 1'b0; if_b.req_word = '0; if_b.req_cs = '0; if_b.req_read = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_sen", a_sen, 2'b11);
    check("rst_sclk", a_sclk, 1'b1);
    check("rst_sdata", a_sdata, 1'b0);
    check("rst_ready", if_a.req_ready, 1'b0);
    check("rst_busy", a_busy, 1'b1);
    check("rst_rsp_valid", if_a.rsp_valid, 1'b0);
    check("rst_rsp_data", if_a.rsp_data, 16'h0000);
    reset = 1'b1;
    @(negedge clock);
    check("rel_ready", if_a.req_ready, 1'b1);
    check("rel_busy_b", b_busy, 1'b0);

    // Write to cs0; slave drives all-ones SDI which must not appear on rsp_data.
    a_slave_word = 16'hFFFF;
    issue_a(16'h0405, 2'd0, 1'b0);
    if_a.req_valid = 1'b0;
    monitor(2, 300);
    check("wr_sen0_low", m_sen_low0, 65);
    check("wr_sen1_low", m_sen_low1, 0);
    check("wr_rx", a_rx, 16'h0405);
    check("wr_rsp_cnt", m_rsp_cnt, 0);
    check("wr_rsp_data", m_rsp_data, 0);
    check("wr_ready_t", m_ready_t, 67);
    check("wr_falls", m_falls, 16);
    check("wr_rises", m_rises, 16);
    check("wr_first_fall", m_first_fall, 2);
    check("wr_width", m_width_bad, 0);
    check("wr_idle", m_bad_idle, 0);

    // Readback from cs1.
    a_slave_word = 16'hA5C3;
    issue_a(16'h8001, 2'd1, 1'b1);
    if_a.req_valid = 1'b0;
    monitor(2, 300);
    check("rd_sen1_low", m_sen_low1, 65);
    check("rd_sen0_low", m_sen_low0, 0);
    check("rd_rsp_cnt", m_rsp_cnt, 1);
    check("rd_rsp_t", m_rsp_t, 65);
    check("rd_data", m_data, 32'h0000A5C3);
    check("rd_rx", a_rx, 16'h8001);
    check("rd_ready_t", m_ready_t, 67);

    // Back-to-back with valid held; word changed mid-flight must not matter.
    a_slave_word = 16'h0000;
    issue_a(16'h0000, 2'd0, 1'b0);
    if_a.req_word = 16'hFFFF;
    monitor(2, 300);
    check("b2b1_rx", a_rx, 16'h0000);
    check("b2b1_sen0_low", m_sen_low0, 65);
    check("b2b_gap", m_ready_t - m_last_low, 3);
    wait_accept();
    if_a.req_valid = 1'b0;
    monitor(2, 300);
    check("b2b2_rx", a_rx, 16'hFFFF);
    check("b2b2_sen0_low", m_sen_low0, 65);
    check("b2b2_ready_t", m_ready_t, 67);

    // Reset at cycle 20 of a read.
    a_slave_word = 16'h5555;
    issue_a(16'h1234, 2'd1, 1'b1);
    if_a.req_valid = 1'b0;
    repeat (20) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("abort_sen", a_sen, 2'b11);
    check("abort_sclk", a_sclk, 1'b1);
    check("abort_sdata", a_sdata, 1'b0);
    check("abort_ready", if_a.req_ready, 1'b0);
    check("abort_rsp_data", if_a.rsp_data, 16'h0000);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      if (if_a.rsp_valid) pulses++;
      @(negedge clock);
    end
    check("abort_no_rsp", pulses, 0);
    check("abort_ready_back", if_a.req_ready, 1'b1);

    a_slave_word = 16'h3C96;
    issue_a(16'hC0DE, 2'd1, 1'b1);
    if_a.req_valid = 1'b0;
    monitor(2, 300);
    check("post_rst_data", m_data, 32'h00003C96);
    check("post_rst_rx", a_rx, 16'hC0DE);
    check("post_rst_rsp_cnt", m_rsp_cnt, 1);

    // Out-of-range select: dummy read returning zero.
    issue_a(16'hFFFF, 2'd3, 1'b1);
    if_a.req_valid = 1'b0;
    monitor(2, 300);
    check("inv_sen_low", m_sen_low0 + m_sen_low1, 0);
    check("inv_sclk", m_falls + m_rises, 0);
    check("inv_rsp_t", m_rsp_t, 1);
    check("inv_data", m_data, 0);
    check("inv_ready_t", m_ready_t, 3);

    // 24-bit word, DIV=4.
    sel = 1'b1;
    b_slave_word = 24'hABCDEF;
    if_b.req_word = 24'h123456; if_b.req_cs = 1'b0; if_b.req_read = 1'b1; if_b.req_valid = 1'b1;
    wait_accept();
    if_b.req_valid = 1'b0;
    monitor(4, 400);
    check("sw_sen0_low", m_sen_low0, 193);
    check("sw_falls", m_falls, 24);
    check("sw_rises", m_rises, 24);
    check("sw_first_fall", m_first_fall, 4);
    check("sw_width", m_width_bad, 0);
    check("sw_rx", b_rx, 24'h123456);
    check("sw_data", m_data, 32'h00ABCDEF);
    check("sw_ready_t", m_ready_t, 197);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
